divisor_multiciclo: RTL
=======================

// Module: divisor_multiciclo
// PURPOSE
// - Multicycle signed 32-bit divider; responder to the control FSM's DivControl start strobe.
// - Returns the one-cycle done flag that the FSM samples on its Divisor input, plus a divide-by-zero flag.
// - Writes quotient to Lo and remainder to Hi; the HI/LO registers load from these via CHi/CLo.
// PARAMETERS
// - WIDTH     32   operand/result width
// - CNT_W     6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
// - clock       in   1      single clock; all state updates on the rising edge
// - reset       in   1      synchronous, active-low reset
// - DivControl  in   1      start strobe; sampled only in IDLE
// - A           in   WIDTH  dividend (rs), two's complement
// - B           in   WIDTH  divisor (rt), two's complement
// - Divisor     out  1      done; high exactly one cycle when Hi/Lo are valid
// - DivZero     out  1      divide-by-zero; high exactly one cycle
// - Hi          out  WIDTH  remainder, held until the next completed division
// - Lo          out  WIDTH  quotient, held until the next completed division
// BEHAVIOUR
// - Reset (reset==0 at an edge): state=IDLE; Hi=Lo=0; Divisor=DivZero=0; counter=0. Applies mid-operation and aborts it.
// - States: IDLE, CALC, FIM.
//   - IDLE->CALC: DivControl==1 and B!=0.
//     - Latch |A| in the quotient shift register and |B|; remainder accumulator=0.
//     - Latch signA and signA^signB; counter=0.
//   - IDLE->IDLE with zero divide: DivControl==1 and B==0.
//     - DivZero=1 for the next cycle only. Divisor stays 0; Hi/Lo unchanged.
//   - CALC: one restoring step per cycle.
//     - {R,Q} shifted left by 1.
//     - If R>=|B| (unsigned, WIDTH+1 bits): R-=|B| and Q[0]=1; otherwise Q[0]=0.
//     - counter++. After WIDTH steps, go to FIM.
//   - FIM (one cycle):
//     - Lo = Q, negated if signs differed.
//     - Hi = R, negated if signA.
//     - Divisor=1 for exactly this one cycle, then IDLE.
// - Latency: start sampled at edge N; Divisor and valid Hi/Lo are visible after edge N+WIDTH+1 (33 for WIDTH=32). Back-to-back start is accepted at edge N+WIDTH+2.
// - DivControl while in CALC or FIM is ignored; there is no queueing.
// - A and B may change after the start edge; only the latched values are used.
// - Magnitudes are computed in WIDTH bits unsigned, so |0x80000000| = 0x80000000.
// - Overflow case 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0, Divisor=1; no flag is raised.
// - Divisor and DivZero are never high in the same cycle.
// CONFIGURATION
// - Macro DIVISOR_DIVU_EN.
//   - Defined: adds input port DivUnsigned (1 bit), sampled with the DivControl start.
//     - DivUnsigned=1: A and B are taken as unsigned magnitudes and no sign correction is applied (MIPS divu).
//   - Undefined: the port is absent and every operation is signed div.
// STRUCTURE
// - Package divisor_pkg holds:
//   - State enum (IDLE=2'b00, CALC=2'b01, FIM=2'b10).
//   - DIV_WIDTH=32 and DIV_CNT_W=6.
//   - Function abs_val(), shared with the multiplier.
// - One sub-module: div_etapa.
//   - Purely combinational restoring step: (R,Q,D) -> (R',Q').
//   - Instantiated once; the FSM, counter and sign fix stay in the top.
// TESTING
// - 100 / 7, start at edge N: Divisor=1 only after edge N+33; Lo=14, Hi=2; DivZero=0 throughout.
// - -100 / 7: Lo=0xFFFFFFF2 (-14), Hi=0xFFFFFFFE (-2). 100 / -7: Lo=-14, Hi=2.
// - 5 / 0 with prior Hi=2, Lo=14: DivZero=1 for one cycle after the start edge; Divisor never asserts; Hi=2, Lo=14 retained.
// - 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0, Divisor pulse after 33 cycles.
// - reset=0 during CALC iteration 10, then 100 / 7:
//   - Reset: Hi=Lo=0, flags=0, IDLE on the next cycle.
//   - Following 100 / 7 completes normally.
// - 100 / 7 started, then DivControl re-pulsed with 9 / 3 at edge N+5:
//   - Only one Divisor pulse, at N+33, with Lo=14, Hi=2.
//   - With DIVISOR_DIVU_EN and DivUnsigned=1: 0xFFFFFFFF / 2 gives Lo=0x7FFFFFFF, Hi=1.

Source files
------------

// File: rtl/divisor_pkg.sv
// ---------------------------------------------------------------------------
// divisor_pkg
// Shared types and constants for the multicycle divider (and the multiplier,
// which reuses abs_val).
//   div_state_t : FSM encoding IDLE=00, CALC=01, FIM=10
//   DIV_WIDTH   : operand/result width (32)
//   DIV_CNT_W   : iteration counter width (6, 2**6 > 32)
//   abs_val()   : two's complement magnitude in DIV_WIDTH unsigned bits;
//                 abs_val(32'h8000_0000) = 32'h8000_0000.
// ---------------------------------------------------------------------------
package divisor_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIM  = 2'b10
   } div_state_t;

   function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x);
      return x[DIV_WIDTH-1] ? (~x + 1'b1) : x;
   endfunction

endpackage

// File: rtl/div_etapa.sv
// ---------------------------------------------------------------------------
// div_etapa
// One combinational restoring-division step.
//   r_i  : partial remainder (always < d_i, so it fits in WIDTH bits)
//   q_i  : quotient shift register (dividend bits still to be consumed at MSB)
//   d_i  : divisor magnitude
//   r_o  : next partial remainder
//   q_o  : next quotient shift register (new quotient bit in bit 0)
// ---------------------------------------------------------------------------
module div_etapa #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] r_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] r_o,
   output logic [WIDTH-1:0] q_o
);

   // {R,Q} << 1: the remainder gains the next dividend bit; one extra bit is
   // kept so a divisor of 0x80000000 compares correctly.
   logic [WIDTH:0] r_shift;
   logic [WIDTH:0] r_sub;
   logic           fits;

   assign r_shift = {r_i, q_i[WIDTH-1]};
   assign r_sub   = r_shift - {1'b0, d_i};
   assign fits    = (r_shift >= {1'b0, d_i});

   // After a successful subtract the result is < d_i, so the top bit is zero
   // and dropping it is lossless.
   assign r_o = fits ? r_sub[WIDTH-1:0] : r_shift[WIDTH-1:0];
   assign q_o = {q_i[WIDTH-2:0], fits};

endmodule

// File: rtl/divisor_multiciclo.sv
// ---------------------------------------------------------------------------
// divisor_multiciclo
// Multicycle signed divider answering the control FSM's DivControl strobe.
// Quotient goes to Lo, remainder to Hi (remainder takes the dividend's sign).
//   clock        : rising-edge clock
//   reset        : synchronous, active-low; aborts any division in progress
//   DivControl   : start strobe, only looked at in IDLE
//   A, B         : dividend / divisor, two's complement
//   DivUnsigned  : (only with DIVISOR_DIVU_EN) 1 = unsigned divu operation
//   Divisor      : done pulse, one cycle, Hi/Lo valid from then on
//   DivZero      : one-cycle pulse when a start arrives with B == 0
//   Hi, Lo       : remainder / quotient, held until the next completion
//   dbg_state_o  : current FSM state (div_state_t encoding) for observation
// Optional feature macro: DIVISOR_DIVU_EN (adds DivUnsigned).
// Timing: start sampled at edge N, WIDTH CALC edges, results and Divisor
// registered at edge N+WIDTH+1; a new start is taken at edge N+WIDTH+2.
// ---------------------------------------------------------------------------
module divisor_multiciclo
   import divisor_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             DivControl,
`ifdef DIVISOR_DIVU_EN
   input  logic             DivUnsigned,
`endif
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Divisor,
   output logic             DivZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic [1:0]       dbg_state_o
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] rem_q,   rem_d;
   logic [WIDTH-1:0] quo_q,   quo_d;
   logic [WIDTH-1:0] dvs_q,   dvs_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_q_q, sign_q_d;
   logic [WIDTH-1:0] hi_q,    hi_d;
   logic [WIDTH-1:0] lo_q,    lo_d;
   logic             done_q,  done_d;
   logic             dz_q,    dz_d;

   logic             is_signed;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             neg_a, neg_b;
   logic [WIDTH-1:0] step_r, step_q;

`ifdef DIVISOR_DIVU_EN
   assign is_signed = ~DivUnsigned;
`else
   assign is_signed = 1'b1;
`endif

   // Unsigned operations take the raw bits and never sign-correct.
   assign neg_a = is_signed & A[WIDTH-1];
   assign neg_b = is_signed & B[WIDTH-1];
   assign mag_a = is_signed ? abs_val(A) : A;
   assign mag_b = is_signed ? abs_val(B) : B;

   div_etapa #(.WIDTH(WIDTH)) u_etapa (
      .r_i (rem_q),
      .q_i (quo_q),
      .d_i (dvs_q),
      .r_o (step_r),
      .q_o (step_q)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      sign_a_d = sign_a_q;
      sign_q_d = sign_q_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dz_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (DivControl) begin
               if (B == '0) begin
                  dz_d = 1'b1;
               end else begin
                  state_d  = CALC;
                  quo_d    = mag_a;
                  dvs_d    = mag_b;
                  rem_d    = '0;
                  sign_a_d = neg_a;
                  sign_q_d = neg_a ^ neg_b;
                  cnt_d    = '0;
               end
            end
         end
         CALC: begin
            rem_d = step_r;
            quo_d = step_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               state_d = FIM;
            end
         end
         FIM: begin
            // Remainder follows the dividend's sign, quotient the sign product.
            lo_d    = sign_q_q ? (~quo_q + 1'b1) : quo_q;
            hi_d    = sign_a_q ? (~rem_q + 1'b1) : rem_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         sign_a_q <= 1'b0;
         sign_q_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         sign_a_q <= sign_a_d;
         sign_q_q <= sign_q_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
      end
   end

   assign Divisor     = done_q;
   assign DivZero     = dz_q;
   assign Hi          = hi_q;
   assign Lo          = lo_q;
   assign dbg_state_o = state_q;

endmodule
